// File: rtl/mod13_count_checker.sv
// Purpose: cycle-accurate shadow checker for a mod-MOD up/down loadable counter.
// Latency: compare/wrap/load-error pulses and counters are registered one cycle after the sampled edge.
// Backpressure: none; passive observer that samples the counter nets every cycle.
module mod13_count_checker #(
    parameter int MOD    = 13,
    parameter int CW     = 4,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              load,
    input  logic [CW-1:0]     data_in,
    input  logic [CW-1:0]     count,
    output logic              match_p,
    output logic              mismatch_p,
    output logic              err_range_p,
    output logic              err_load_p,
    output logic              wrap_up_p,
    output logic              wrap_dn_p,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              first_err_vld,
    output logic [CW-1:0]     first_exp,
    output logic [CW-1:0]     first_act
);

    localparam logic [CW-1:0] MAX_V = CW'(MOD - 1);

    logic [CW-1:0]     exp_q, exp_d;
    logic              exp_vld_q, exp_vld_d;
    logic              exp_wu_q, exp_wu_d;
    logic              exp_wd_q, exp_wd_d;
    logic              match_q, match_d;
    logic              mismatch_q, mismatch_d;
    logic              range_q, range_d;
    logic              load_err_q, load_err_d;
    logic              wrap_up_q, wrap_up_d;
    logic              wrap_dn_q, wrap_dn_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              first_vld_q, first_vld_d;
    logic [CW-1:0]     first_exp_q, first_exp_d;
    logic [CW-1:0]     first_act_q, first_act_d;

    logic cnt_bad;
    logic din_bad;
    logic err_any;

    // Compare against the prediction made on the previous edge.
    always_comb begin
        cnt_bad    = (count > MAX_V);
        din_bad    = (data_in > MAX_V);
        range_d    = exp_vld_q && cnt_bad;
        match_d    = exp_vld_q && !cnt_bad && (count == exp_q);
        mismatch_d = exp_vld_q && !cnt_bad && (count != exp_q);
        wrap_up_d  = match_d && exp_wu_q;
        wrap_dn_d  = match_d && exp_wd_q;
        load_err_d = load && din_bad;
        err_any    = mismatch_d || range_d;

        wrap_cnt_d = wrap_cnt_q + WRAP_W'(wrap_up_d || wrap_dn_d);
        err_cnt_d  = err_cnt_q;
        if (err_any && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end

        first_vld_d = first_vld_q;
        first_exp_d = first_exp_q;
        first_act_d = first_act_q;
        if (err_any && !first_vld_q) begin
            first_vld_d = 1'b1;
            first_exp_d = exp_q;
            first_act_d = count;
        end
    end

    // Next prediction always rebases on the observed count so one fault costs one mismatch.
    always_comb begin
        exp_d     = exp_q;
        exp_vld_d = 1'b1;
        exp_wu_d  = 1'b0;
        exp_wd_d  = 1'b0;
        if (load && !din_bad) begin
            exp_d = data_in;
        end else if (load) begin
            exp_vld_d = 1'b0;
        end else if (cnt_bad) begin
            exp_vld_d = 1'b0;
        end else if (mode) begin
            if (count == MAX_V) begin
                exp_d    = '0;
                exp_wu_d = 1'b1;
            end else begin
                exp_d = count + CW'(1);
            end
        end else begin
            if (count == '0) begin
                exp_d    = MAX_V;
                exp_wd_d = 1'b1;
            end else begin
                exp_d = count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q       <= '0;
            exp_vld_q   <= 1'b1;
            exp_wu_q    <= 1'b0;
            exp_wd_q    <= 1'b0;
            match_q     <= 1'b0;
            mismatch_q  <= 1'b0;
            range_q     <= 1'b0;
            load_err_q  <= 1'b0;
            wrap_up_q   <= 1'b0;
            wrap_dn_q   <= 1'b0;
            wrap_cnt_q  <= '0;
            err_cnt_q   <= '0;
            first_vld_q <= 1'b0;
            first_exp_q <= '0;
            first_act_q <= '0;
        end else begin
            exp_q       <= exp_d;
            exp_vld_q   <= exp_vld_d;
            exp_wu_q    <= exp_wu_d;
            exp_wd_q    <= exp_wd_d;
            match_q     <= match_d;
            mismatch_q  <= mismatch_d;
            range_q     <= range_d;
            load_err_q  <= load_err_d;
            wrap_up_q   <= wrap_up_d;
            wrap_dn_q   <= wrap_dn_d;
            wrap_cnt_q  <= wrap_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_vld_q <= first_vld_d;
            first_exp_q <= first_exp_d;
            first_act_q <= first_act_d;
        end
    end

    assign match_p       = match_q;
    assign mismatch_p    = mismatch_q;
    assign err_range_p   = range_q;
    assign err_load_p    = load_err_q;
    assign wrap_up_p     = wrap_up_q;
    assign wrap_dn_p     = wrap_dn_q;
    assign wrap_cnt      = wrap_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_vld = first_vld_q;
    assign first_exp     = first_exp_q;
    assign first_act     = first_act_q;

endmodule

// File: tb/tb_mod13_count_checker.sv
// Bench for mod13_count_checker: scenario tasks with a scoreboard of expected output snapshots.
module tb_mod13_count_checker;

    typedef struct packed {
        logic       match;
        logic       mismatch;
        logic       range;
        logic       load_err;
        logic       wu;
        logic       wd;
        logic [7:0] wrap_cnt;
        logic [7:0] err_cnt;
        logic       fvld;
        logic [3:0] fexp;
        logic [3:0] fact;
    } out_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       load;
    logic [3:0] data_in;
    logic [3:0] count;
    logic       match_p, mismatch_p, err_range_p, err_load_p, wrap_up_p, wrap_dn_p;
    logic [7:0] wrap_cnt;
    logic [7:0] err_cnt;
    logic       first_err_vld;
    logic [3:0] first_exp;
    logic [3:0] first_act;

    out_t obs;
    assign obs = {match_p, mismatch_p, err_range_p, err_load_p, wrap_up_p, wrap_dn_p,
                  wrap_cnt, err_cnt, first_err_vld, first_exp, first_act};

    mod13_count_checker dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .load         (load),
        .data_in      (data_in),
        .count        (count),
        .match_p      (match_p),
        .mismatch_p   (mismatch_p),
        .err_range_p  (err_range_p),
        .err_load_p   (err_load_p),
        .wrap_up_p    (wrap_up_p),
        .wrap_dn_p    (wrap_dn_p),
        .wrap_cnt     (wrap_cnt),
        .err_cnt      (err_cnt),
        .first_err_vld(first_err_vld),
        .first_exp    (first_exp),
        .first_act    (first_act)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    out_t sb[$];

    // Reference model state
    int   m_exp = 0;
    bit   m_vld = 1'b1;
    bit   m_wu  = 1'b0;
    bit   m_wd  = 1'b0;
    int   m_wrap = 0;
    int   m_err  = 0;
    bit   m_fvld = 1'b0;
    int   m_fexp = 0;
    int   m_fact = 0;

    task automatic model_step(input bit r, input bit md, input bit ld, input int din, input int cnt,
                              output out_t o);
        o = '0;
        if (r) begin
            m_exp = 0; m_vld = 1'b1; m_wu = 1'b0; m_wd = 1'b0;
            m_wrap = 0; m_err = 0; m_fvld = 1'b0; m_fexp = 0; m_fact = 0;
            return;
        end
        if (m_vld) begin
            if (cnt >= 13)          o.range = 1'b1;
            else if (cnt == m_exp) begin
                o.match = 1'b1;
                o.wu    = m_wu;
                o.wd    = m_wd;
            end else                o.mismatch = 1'b1;
        end
        o.load_err = ld && (din >= 13);
        if (o.wu || o.wd) m_wrap = (m_wrap + 1) % 256;
        if ((o.mismatch || o.range) && m_err < 255) m_err++;
        if ((o.mismatch || o.range) && !m_fvld) begin
            m_fvld = 1'b1; m_fexp = m_exp; m_fact = cnt;
        end
        m_wu = 1'b0;
        m_wd = 1'b0;
        m_vld = 1'b1;
        if (ld && din < 13)      m_exp = din;
        else if (ld)             m_vld = 1'b0;
        else if (cnt >= 13)      m_vld = 1'b0;
        else if (md) begin
            m_wu  = (cnt == 12);
            m_exp = (cnt == 12) ? 0 : cnt + 1;
        end else begin
            m_wd  = (cnt == 0);
            m_exp = (cnt == 0) ? 12 : cnt - 1;
        end
        o.wrap_cnt = 8'(m_wrap);
        o.err_cnt  = 8'(m_err);
        o.fvld     = m_fvld;
        o.fexp     = 4'(m_fexp);
        o.fact     = 4'(m_fact);
    endtask

    task automatic drive(input bit r, input bit md, input bit ld, input int din, input int cnt);
        out_t e;
        rst = r; mode = md; load = ld; data_in = 4'(din); count = 4'(cnt);
        model_step(r, md, ld, din, cnt, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 0, 0);
            void'(sb.pop_front());
        end
    endtask

    task automatic test_reset();
        out_t e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 0, 0);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h expected %h", i, obs, e);
            end
        end
        n_checks++;
        if (obs !== out_t'(0)) begin
            n_fail++;
            $display("FAIL reset_zero: got %h expected 0", obs);
        end
    endtask

    task automatic test_up_count();
        int   seq[15] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 0, 1};
        int   n_match = 0;
        int   n_wu    = 0;
        out_t e;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b1, 1'b0, 0, seq[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL up_count[%0d]: got %h expected %h", i, obs, e);
            end
            if (match_p) n_match++;
            if (wrap_up_p) n_wu++;
        end
        n_checks++;
        if (n_match !== 15 || n_wu !== 1 || wrap_cnt !== 8'd1 || err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL up_totals: got match=%0d wu=%0d wrap=%0d err=%0d expected 15 1 1 0",
                     n_match, n_wu, wrap_cnt, err_cnt);
        end
    endtask

    task automatic test_down_count();
        int   seq[11] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 12};
        int   n_match = 0;
        int   n_wd    = 0;
        out_t e;
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 9, 0);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL down_load: got %h expected %h", obs, e);
        end
        if (match_p) n_match++;
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, 1'b0, 1'b0, 0, seq[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL down_count[%0d]: got %h expected %h", i, obs, e);
            end
            if (match_p) n_match++;
            if (wrap_dn_p) n_wd++;
        end
        n_checks++;
        if (n_match !== 12 || n_wd !== 1 || wrap_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL down_totals: got match=%0d wd=%0d wrap=%0d expected 12 1 1",
                     n_match, n_wd, wrap_cnt);
        end
    endtask

    task automatic test_mismatch();
        int   seq[7] = '{0, 1, 2, 3, 5, 6, 7};
        out_t e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, 1'b0, 0, seq[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL mismatch_seq[%0d]: got %h expected %h", i, obs, e);
            end
            if (i == 4) begin
                n_checks++;
                if (mismatch_p !== 1'b1 || err_cnt !== 8'd1 || first_err_vld !== 1'b1 ||
                    first_exp !== 4'd4 || first_act !== 4'd5) begin
                    n_fail++;
                    $display("FAIL mismatch_capture: got mis=%b err=%0d vld=%b exp=%0d act=%0d expected 1 1 1 4 5",
                             mismatch_p, err_cnt, first_err_vld, first_exp, first_act);
                end
            end
            if (i == 5) begin
                n_checks++;
                if (match_p !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mismatch_resync: got match=%b expected 1", match_p);
                end
            end
        end
    endtask

    task automatic test_range();
        int   seq[5] = '{0, 1, 14, 3, 4};
        out_t e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 0, seq[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL range_seq[%0d]: got %h expected %h", i, obs, e);
            end
            if (i == 3) begin
                n_checks++;
                if ({match_p, mismatch_p, err_range_p} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL range_skip: got %b expected 000", {match_p, mismatch_p, err_range_p});
                end
            end
        end
        n_checks++;
        if (match_p !== 1'b1 || err_cnt !== 8'd1 || first_exp !== 4'd2 || first_act !== 4'd14) begin
            n_fail++;
            $display("FAIL range_totals: got match=%b err=%0d exp=%0d act=%0d expected 1 1 2 14",
                     match_p, err_cnt, first_exp, first_act);
        end
    endtask

    task automatic test_bad_load();
        out_t e;
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 13, 0);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e || err_load_p !== 1'b1 || match_p !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_load: got %h expected %h with err_load and match set", obs, e);
        end
        drive(1'b0, 1'b1, 1'b0, 0, 1);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e || {match_p, mismatch_p, err_range_p, err_load_p} !== 4'b0000) begin
            n_fail++;
            $display("FAIL bad_load_skip: got %h expected %h with no pulses", obs, e);
        end
        drive(1'b0, 1'b1, 1'b0, 0, 2);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e || match_p !== 1'b1 || err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL bad_load_resume: got %h expected %h with match and err_cnt 0", obs, e);
        end
    endtask

    task automatic test_saturate_and_reset();
        out_t e;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b1, 1'b0, 0, 3);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL saturate[%0d]: got %h expected %h", i, obs, e);
            end
        end
        n_checks++;
        if (err_cnt !== 8'd255 || first_exp !== 4'd0 || first_act !== 4'd3) begin
            n_fail++;
            $display("FAIL saturate_hold: got err=%0d exp=%0d act=%0d expected 255 0 3",
                     err_cnt, first_exp, first_act);
        end
        drive(1'b1, 1'b1, 1'b0, 0, 3);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e || obs !== out_t'(0)) begin
            n_fail++;
            $display("FAIL midrun_reset: got %h expected 0", obs);
        end
        drive(1'b0, 1'b1, 1'b0, 0, 0);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e || match_p !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_match: got %h expected %h", obs, e);
        end
    endtask

    initial begin
        rst = 1'b1; mode = 1'b1; load = 1'b0; data_in = '0; count = '0;
        test_reset();
        test_up_count();
        test_down_count();
        test_mismatch();
        test_range();
        test_bad_load();
        test_saturate_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
